// File: rtl/keypad_scan_ctrl.sv
// Keypad scan sequencer: divides clk into scan ticks, debounces the scanner's
// press/key outputs and queues each accepted key-down for the MCU.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV   = 50000,
  parameter int DEBOUNCE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            press,
  input  logic [3:0]                      key_in,
  output logic                            scan_en,
  output logic [3:0]                      key_data,
  output logic                            key_valid,
  input  logic                            key_ack,
  output logic                            intr,
  output logic                            overflow,
  input  logic                            ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]     count
);

  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int DCNT_W = $clog2(DEBOUNCE + 1);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;

  localparam logic [3:0]        NO_KEY   = 4'd13;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DCNT_W-1:0] DEB_LAST = DCNT_W'(DEBOUNCE);
  localparam logic [CW-1:0]     FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEB_DN = 2'd1,
    HELD   = 2'd2,
    DEB_UP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [3:0]        cand_q, cand_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [3:0]        mem_q [FIFO_DEPTH];

  logic              tick;
  logic              down;
  logic              sample_down;
  logic              sample_up;
  logic [DCNT_W-1:0] dcnt_inc;
  logic              push;
  logic              full;
  logic              empty;
  logic              do_pop;
  logic              do_push;
  logic              ovf_set;

  always_comb begin
    tick        = (div_q == DIV_LAST);
    div_d       = tick ? '0 : div_q + 1'b1;
    down        = press && (key_in != NO_KEY);
    sample_down = tick && down;
    sample_up   = tick && !down;
    dcnt_inc    = dcnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    dcnt_d  = dcnt_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_down) begin
          cand_d = key_in;
          dcnt_d = DCNT_W'(1);
          if (DEBOUNCE == 1) begin
            push    = 1'b1;
            state_d = HELD;
          end else begin
            state_d = DEB_DN;
          end
        end
      end
      DEB_DN: begin
        if (sample_down) begin
          if (key_in == cand_q) begin
            dcnt_d = dcnt_inc;
            if (dcnt_inc == DEB_LAST) begin
              push    = 1'b1;
              state_d = HELD;
            end
          end else begin
            cand_d = key_in;
            dcnt_d = DCNT_W'(1);
          end
        end else if (sample_up) begin
          state_d = IDLE;
        end
      end
      HELD: begin
        if (sample_up) begin
          dcnt_d  = DCNT_W'(1);
          state_d = (DEBOUNCE == 1) ? IDLE : DEB_UP;
        end
      end
      DEB_UP: begin
        if (sample_up) begin
          dcnt_d = dcnt_inc;
          if (dcnt_inc == DEB_LAST) state_d = IDLE;
        end else if (sample_down) begin
          state_d = HELD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A down sample in IDLE withholds the advance so the row stays on the candidate.
  assign scan_en = (state_q == IDLE) && sample_up;

  always_comb begin
    full       = (count_q == FULL_CNT);
    empty      = (count_q == '0);
    do_pop     = key_ack && !empty;
    do_push    = push && (!full || do_pop);
    ovf_set    = push && full && !do_pop;
    wptr_d     = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = do_pop ? rptr_q + 1'b1 : rptr_q;
    count_d    = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
    overflow_d = ovf_set || (overflow_q && !ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      dcnt_q     <= '0;
      cand_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      dcnt_q     <= dcnt_d;
      cand_q     <= cand_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: key_data is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem_q[wptr_q] <= key_in;
  end

  assign key_valid = !empty;
  assign intr      = !empty;
  assign key_data  = empty ? 4'd0 : mem_q[rptr_q];
  assign overflow  = overflow_q;
  assign count     = count_q;

endmodule
